spi_mem_controller: RTL and testbench

- SPI slave front-end that sits directly upstream of the data memory (DATA_WIDTH-bit words, ADDR_WIDTH-bit address, synchronous write on we=1, registered read on we=0).
- Decodes a serial command frame (address plus read/write bit) and drives the memory's address, write enable and write data.
- On reads, captures the memory's registered output and shifts it out on MISO.
- Synchronises and edge-detects the asynchronous SPI pins internally, so the whole block runs on the system clock.

---
 rtl/spi_mem_controller.sv | 153 +++++++++++++++
 tb/tb_spi_mem_controller.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/spi_mem_controller.sv
// rtl/spi_mem_controller.sv - SPI mode-0 slave front-end that turns serial frames into data memory accesses
module spi_mem_controller #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  ce,
    input  logic                  spi_cs_n,
    input  logic                  spi_sclk,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  miso_oe,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  busy
);
    localparam int CMD_BITS = ADDR_WIDTH + 1;
    localparam int SR_W     = (CMD_BITS > DATA_WIDTH) ? CMD_BITS : DATA_WIDTH;
    localparam int CNT_W    = $clog2(SR_W + 1);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_BITS - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE, GET_CMD, READ_ADDR, READ_CAP, SHIFT_OUT, SHIFT_IN, WRITE, DONE
    } state_t;

    state_t            state;
    logic              cs_s1, cs_s2;
    logic              sclk_s1, sclk_s2, sclk_s3;
    logic              mosi_s1, mosi_s2;
    logic [1:0]        warm;
    logic              armed;
    logic              seen_rise;
    logic [CNT_W-1:0]  cnt;
    logic [SR_W-1:0]   sr;
    logic              rise, fall;

    assign rise = sclk_s2 & ~sclk_s3;
    assign fall = ~sclk_s2 & sclk_s3;

    always_ff @(posedge clk or negedge ce) begin
        if (!ce) begin
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_s3 <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
            warm    <= 2'b00;
            armed   <= 1'b0;
        end else begin
            cs_s1   <= spi_cs_n;
            cs_s2   <= cs_s1;
            sclk_s1 <= spi_sclk;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            mosi_s1 <= spi_mosi;
            mosi_s2 <= mosi_s1;
            // cs_n must be seen high through the real synchroniser path before a frame may start
            warm    <= {warm[0], 1'b1};
            armed   <= armed | (warm[1] & cs_s2);
        end
    end

    always_ff @(posedge clk or negedge ce) begin
        if (!ce) begin
            state       <= IDLE;
            cnt         <= '0;
            sr          <= '0;
            seen_rise   <= 1'b0;
            spi_miso    <= 1'b0;
            miso_oe     <= 1'b0;
            mem_address <= '0;
            mem_we      <= 1'b0;
            mem_data_in <= '0;
            busy        <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (cs_s2 && state != IDLE && state != WRITE && state != DONE) begin
                state    <= IDLE;
                busy     <= 1'b0;
                miso_oe  <= 1'b0;
                spi_miso <= 1'b0;
                cnt      <= '0;
            end else begin
                case (state)
                    IDLE: if (armed && !cs_s2) begin
                        state <= GET_CMD;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        sr    <= '0;
                    end
                    GET_CMD: if (rise) begin
                        sr <= {sr[SR_W-2:0], mosi_s2};
                        if (cnt == CMD_LAST) begin
                            // the incoming bit is R/W; the address already sits in the low bits
                            mem_address <= sr[ADDR_WIDTH-1:0];
                            cnt         <= '0;
                            state       <= mosi_s2 ? READ_ADDR : SHIFT_IN;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    READ_ADDR: state <= READ_CAP;
                    READ_CAP: begin
                        sr        <= SR_W'(mem_data_out);
                        spi_miso  <= mem_data_out[DATA_WIDTH-1];
                        miso_oe   <= 1'b1;
                        seen_rise <= 1'b0;
                        state     <= SHIFT_OUT;
                    end
                    SHIFT_OUT: if (rise) begin
                        seen_rise <= 1'b1;
                        if (cnt == DATA_LAST) begin
                            state    <= DONE;
                            miso_oe  <= 1'b0;
                            spi_miso <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (fall && seen_rise) begin
                        // the fall right after the command frame has no preceding data rise
                        seen_rise <= 1'b0;
                        sr        <= sr << 1;
                        spi_miso  <= sr[DATA_WIDTH-2];
                    end
                    SHIFT_IN: if (rise) begin
                        sr <= {sr[SR_W-2:0], mosi_s2};
                        if (cnt == DATA_LAST) begin
                            mem_data_in <= {sr[DATA_WIDTH-2:0], mosi_s2};
                            mem_we      <= 1'b1;
                            state       <= WRITE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    WRITE: begin
                        state <= cs_s2 ? IDLE : DONE;
                        busy  <= ~cs_s2;
                    end
                    DONE: if (cs_s2) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_mem_controller.sv
// tb/tb_spi_mem_controller.sv - directed and randomized SPI frames against a memory reference model
module tb_spi_mem_controller;
    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       ce;
    logic       spi_cs_n, spi_sclk, spi_mosi;
    logic       spi_miso, miso_oe, mem_we, busy;
    logic [6:0] mem_address;
    logic [7:0] mem_data_in;
    logic [7:0] mem_data_out = 8'h00;

    logic [7:0] mem     [0:127];
    logic [7:0] ref_mem [0:127];
    int         we_count = 0;
    logic [6:0] we_addr  = '0;
    logic [7:0] we_data  = '0;
    int         checks = 0;
    int         errors = 0;

    spi_mem_controller #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) dut (
        .clk(clk), .ce(ce), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .miso_oe(miso_oe), .mem_address(mem_address), .mem_we(mem_we),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_address] <= mem_data_in;
        else        mem_data_out     <= mem[mem_address];
    end

    always @(negedge clk) begin
        if (mem_we) begin
            we_count = we_count + 1;
            we_addr  = mem_address;
            we_data  = mem_data_in;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [15:0] tx, input int n,
                            output logic [15:0] rx, output logic [15:0] oe);
        rx = '0;
        oe = '0;
        for (int i = 0; i < n; i++) begin
            spi_mosi = tx[n-1-i];
            clk_wait(HALF);
            spi_sclk = 1'b1;
            rx = {rx[14:0], spi_miso};
            oe = {oe[14:0], miso_oe};
            clk_wait(HALF);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic spi_write(input logic [6:0] a, input logic [7:0] d, input int gap);
        logic [15:0] rx, oe;
        int wc0;
        wc0 = we_count;
        spi_cs_n = 1'b0;
        spi_bits({a, 1'b0, d}, 16, rx, oe);
        clk_wait(HALF);
        spi_cs_n = 1'b1;
        check("wr_we_pulses", 32'(we_count - wc0), 32'd1);
        check("wr_addr", 32'(we_addr), 32'(a));
        check("wr_data", 32'(we_data), 32'(d));
        check("wr_miso_oe", 32'(oe), 32'd0);
        ref_mem[a] = d;
        clk_wait(gap);
        if (gap >= 4) check("wr_busy_after", 32'(busy), 32'd0);
    endtask

    task automatic spi_read(input logic [6:0] a, input int gap);
        logic [15:0] rx, oe;
        int wc0;
        wc0 = we_count;
        spi_cs_n = 1'b0;
        spi_bits({a, 1'b1, 8'h00}, 16, rx, oe);
        clk_wait(HALF);
        check("rd_oe_done", 32'(miso_oe), 32'd0);
        spi_cs_n = 1'b1;
        check("rd_data", 32'(rx[7:0]), 32'(ref_mem[a]));
        check("rd_oe_window", 32'(oe), 32'h0000_00FF);
        check("rd_no_write", 32'(we_count - wc0), 32'd0);
        clk_wait(gap);
        if (gap >= 4) check("rd_busy_after", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [15:0] rx, oe;
        logic [6:0]  a;
        logic [7:0]  d;
        int          wc0;

        for (int i = 0; i < 128; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        ce = 1'b0; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
        clk_wait(3);
        check("rst_outputs", {20'd0, spi_miso, miso_oe, mem_we, busy, mem_data_in},
              32'd0);
        check("rst_addr", 32'(mem_address), 32'd0);
        ce = 1'b1;
        clk_wait(5);

        spi_write(7'h12, 8'hA5, 6);
        spi_read(7'h12, 6);
        spi_write(7'h7F, 8'h3C, 6);
        spi_read(7'h7F, 6);
        spi_read(7'h00, 6);

        // abort a write to 0x05 after 4 data bits
        wc0 = we_count;
        spi_cs_n = 1'b0;
        spi_bits({4'h0, 7'h05, 1'b0, 4'b1011}, 12, rx, oe);
        clk_wait(HALF);
        spi_cs_n = 1'b1;
        clk_wait(5);
        check("abort_no_write", 32'(we_count - wc0), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        spi_read(7'h05, 6);

        // reset in the middle of a read, after 3 data bits
        a = 7'($urandom);
        spi_cs_n = 1'b0;
        spi_bits({5'd0, a, 1'b1, 3'b000}, 11, rx, oe);
        clk_wait(2);
        ce = 1'b0;
        #1;
        check("midrst_outputs", {20'd0, spi_miso, miso_oe, mem_we, busy, mem_data_in},
              32'd0);
        check("midrst_addr", 32'(mem_address), 32'd0);
        clk_wait(2);
        spi_cs_n = 1'b1;
        clk_wait(2);
        ce = 1'b1;
        clk_wait(5);
        a = 7'($urandom);
        d = 8'($urandom);
        spi_write(a, d, 6);
        spi_read(a, 6);

        // back-to-back frames with cs_n high for only 3 clk
        a = 7'($urandom);
        d = 8'($urandom);
        spi_write(a, d, 3);
        spi_read(a, 3);
        spi_write(7'(a + 7'd1), ~d, 3);
        spi_read(7'(a + 7'd1), 6);

        for (int k = 0; k < 6; k++) begin
            a = 7'($urandom);
            d = 8'($urandom);
            spi_write(a, d, 4 + int'($urandom_range(0, 3)));
            spi_read(($urandom_range(0, 1) == 0) ? a : 7'($urandom), 5);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
